// File: rtl/store_write_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_write_buffer_pkg
// Shared definitions for the store write buffer: bus FSM state encoding,
// lane/data widths and the word-offset bit range of a byte address.
// ---------------------------------------------------------------------------
package store_write_buffer_pkg;

  typedef enum logic [0:0] {
    BUS_IDLE  = 1'b0,
    BUS_WRITE = 1'b1
  } bus_state_e;

  localparam int BE_W        = 4;
  localparam int DATA_W      = 32;
  localparam int WORD_OFF_HI = 1;
  localparam int WORD_OFF_LO = 0;
  localparam int WORD_OFF_W  = WORD_OFF_HI - WORD_OFF_LO + 1;

  // True when at least one byte lane is enabled.
  function automatic logic be_any(input logic [BE_W-1:0] be);
    return |be;
  endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// ---------------------------------------------------------------------------
// store_write_buffer_if
// Avalon-MM style write channel between the store buffer and data memory.
//   oBusAddress     : word-aligned write address
//   oBusWriteData   : write data
//   oBusByteEnable  : lane enables
//   oBusWrite       : write request
//   iBusWaitRequest : slave not ready, request must be held
// master = store buffer side, slave = memory side.
// ---------------------------------------------------------------------------
interface store_write_buffer_if
  import store_write_buffer_pkg::*;
#(
  parameter int AW = 32
);
  logic [AW-1:0]     oBusAddress;
  logic [DATA_W-1:0] oBusWriteData;
  logic [BE_W-1:0]   oBusByteEnable;
  logic              oBusWrite;
  logic              iBusWaitRequest;

  modport master (
    output oBusAddress, oBusWriteData, oBusByteEnable, oBusWrite,
    input  iBusWaitRequest
  );

  modport slave (
    input  oBusAddress, oBusWriteData, oBusByteEnable, oBusWrite,
    output iBusWaitRequest
  );
endinterface

// File: rtl/store_fifo.sv
// ---------------------------------------------------------------------------
// store_fifo
// Generic DEPTH x W register FIFO. Besides head/next it exposes every slot
// and a per-slot valid vector so the owner can search pending entries.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push/i_data  : enqueue (ignored when full)
//   i_pop          : dequeue head (ignored when empty)
//   o_head/o_next  : entry at read pointer and the one after it
//   o_entries      : raw slot contents, o_valid marks occupied slots
//   o_count, o_full, o_empty : occupancy
// ---------------------------------------------------------------------------
module store_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 66,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_push,
  input  logic [W-1:0]              i_data,
  input  logic                      i_pop,
  output logic [W-1:0]              o_head,
  output logic [W-1:0]              o_next,
  output logic [DEPTH-1:0][W-1:0]   o_entries,
  output logic [DEPTH-1:0]          o_valid,
  output logic [CNT_W-1:0]          o_count,
  output logic                      o_full,
  output logic                      o_empty
);
  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_next_ptr;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == {CNT_W{1'b0}});
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign w_next_ptr = r_rd_ptr + PTR_W'(1);
  assign o_head     = r_mem[r_rd_ptr];
  assign o_next     = r_mem[w_next_ptr];
  assign o_count    = r_count;

  // A slot is occupied when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic [PTR_W-1:0] w_off;
    assign w_off        = PTR_W'(g) - r_rd_ptr;
    assign o_valid[g]   = ({1'b0, w_off} < r_count);
    assign o_entries[g] = r_mem[g];
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_next_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {W{1'b0}};
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end
endmodule

// File: rtl/store_write_buffer.sv
// ---------------------------------------------------------------------------
// store_write_buffer
// Queues committed stores and drains them in order to data memory over an
// Avalon-MM style write channel; flags loads that hit a pending store word.
//   iCLK, iRSTn        : clock, async active-low reset
//   iWrReq, iAddress, iData, iByteEnable, iException : store from formatter
//   oFull / oEmpty     : stall / fence status
//   oStoreFault        : one-cycle pulse when a misaligned store is dropped
//   iLoadAddr, oLoadHazard : word-granular load-vs-pending-store check
//   bus                : write channel (master side)
// ---------------------------------------------------------------------------
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iWrReq,
  input  logic [AW-1:0]     iAddress,
  input  logic [DATA_W-1:0] iData,
  input  logic [BE_W-1:0]   iByteEnable,
  input  logic              iException,
  output logic              oFull,
  output logic              oEmpty,
  output logic              oStoreFault,
  input  logic [AW-1:0]     iLoadAddr,
  output logic              oLoadHazard,
  store_write_buffer_if.master bus
);
  localparam int WA_W  = AW - WORD_OFF_W;
  localparam int ENT_W = WA_W + DATA_W + BE_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ENT_W-1:0]             w_in_entry;
  logic [ENT_W-1:0]             w_head;
  logic [ENT_W-1:0]             w_next;
  logic [ENT_W-1:0]             w_load_entry;
  logic [DEPTH-1:0][ENT_W-1:0]  w_entries;
  logic [DEPTH-1:0]             w_valid;
  logic [CNT_W-1:0]             w_count;
  logic                         w_fifo_full;
  logic                         w_fifo_empty;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_load;
  logic                         w_hazard;
  logic                         w_unused_ok;
  bus_state_e                   r_state;
  bus_state_e                   w_next_state;
  logic [AW-1:0]                r_bus_addr;
  logic [DATA_W-1:0]            r_bus_data;
  logic [BE_W-1:0]              r_bus_be;
  logic                         r_store_fault;

  // Byte offsets are irrelevant: both buffer and hazard check work on words.
  assign w_unused_ok = ^{iAddress[WORD_OFF_HI:WORD_OFF_LO], iLoadAddr[WORD_OFF_HI:WORD_OFF_LO]};

  assign w_in_entry = {iAddress[AW-1:WORD_OFF_HI+1], iData, iByteEnable};
  assign w_push     = iWrReq & ~w_fifo_full & ~iException & be_any(iByteEnable);

  store_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .i_clk     (iCLK),
    .i_rst_n   (iRSTn),
    .i_push    (w_push),
    .i_data    (w_in_entry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_next    (w_next),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_count   (w_count),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // Bus FSM next state; on completion the successor is either the next FIFO
  // slot or, if the FIFO held only the in-flight entry, the store arriving now.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_load_entry = w_head;
    case (r_state)
      BUS_IDLE: begin
        if (!w_fifo_empty) begin
          w_load       = 1'b1;
          w_load_entry = w_head;
          w_next_state = BUS_WRITE;
        end else begin
          w_next_state = BUS_IDLE;
        end
      end
      BUS_WRITE: begin
        if (!bus.iBusWaitRequest) begin
          w_pop = 1'b1;
          if (w_count > CNT_W'(1)) begin
            w_load       = 1'b1;
            w_load_entry = w_next;
            w_next_state = BUS_WRITE;
          end else if (w_push) begin
            w_load       = 1'b1;
            w_load_entry = w_in_entry;
            w_next_state = BUS_WRITE;
          end else begin
            w_next_state = BUS_IDLE;
          end
        end else begin
          w_next_state = BUS_WRITE;
        end
      end
      default: begin
        w_next_state = BUS_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) r_state <= BUS_IDLE;
    else        r_state <= w_next_state;
  end

  // Bus payload registers; held stable between loads so wait states see no change.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_bus_addr <= {AW{1'b0}};
      r_bus_data <= {DATA_W{1'b0}};
      r_bus_be   <= {BE_W{1'b0}};
    end else if (w_load) begin
      r_bus_addr <= {w_load_entry[ENT_W-1 -: WA_W], {WORD_OFF_W{1'b0}}};
      r_bus_data <= w_load_entry[BE_W +: DATA_W];
      r_bus_be   <= w_load_entry[BE_W-1:0];
    end
  end

  // Misaligned-store pulse; independent of buffer occupancy.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) r_store_fault <= 1'b0;
    else        r_store_fault <= iWrReq & iException;
  end

  // Word-granular hazard search over every occupied slot, in-flight included.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i][ENT_W-1 -: WA_W] == iLoadAddr[AW-1:WORD_OFF_HI+1])) begin
        w_hazard = 1'b1;
      end else begin
        w_hazard = w_hazard;
      end
    end
  end

  assign oFull              = w_fifo_full;
  assign oEmpty             = w_fifo_empty & (r_state == BUS_IDLE);
  assign oStoreFault        = r_store_fault;
  assign oLoadHazard        = w_hazard;
  assign bus.oBusWrite      = (r_state == BUS_WRITE);
  assign bus.oBusAddress    = r_bus_addr;
  assign bus.oBusWriteData  = r_bus_data;
  assign bus.oBusByteEnable = r_bus_be;
endmodule

// File: tb/tb_store_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_write_buffer
// Directed stimulus with a scoreboard queue of expected bus writes; a
// negedge monitor pops and compares on every completed bus transfer.
// ---------------------------------------------------------------------------
module tb_store_write_buffer;
  logic        iCLK;
  logic        iRSTn;
  logic        iWrReq;
  logic [31:0] iAddress;
  logic [31:0] iData;
  logic [3:0]  iByteEnable;
  logic        iException;
  logic        oFull;
  logic        oEmpty;
  logic        oStoreFault;
  logic [31:0] iLoadAddr;
  logic        oLoadHazard;

  int n_vec = 0;
  int n_err = 0;

  // Expected bus write: {address, data, byte enable}
  logic [67:0] sb [$];

  logic [31:0] s_a;
  logic [31:0] s_d;
  logic [3:0]  s_be;

  store_write_buffer_if #(.AW(32)) bus_if ();

  store_write_buffer #(.DEPTH(4), .AW(32)) dut (
    .iCLK        (iCLK),
    .iRSTn       (iRSTn),
    .iWrReq      (iWrReq),
    .iAddress    (iAddress),
    .iData       (iData),
    .iByteEnable (iByteEnable),
    .iException  (iException),
    .oFull       (oFull),
    .oEmpty      (oEmpty),
    .oStoreFault (oStoreFault),
    .iLoadAddr   (iLoadAddr),
    .oLoadHazard (oLoadHazard),
    .bus         (bus_if)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic exc, input logic exp_acc);
    @(posedge iCLK); #1;
    iWrReq = 1'b1; iAddress = a; iData = d; iByteEnable = be; iException = exc;
    if (exp_acc) sb.push_back({a & 32'hFFFF_FFFC, d, be});
    @(posedge iCLK); #1;
    iWrReq = 1'b0; iException = 1'b0;
  endtask

  // Monitor: a transfer completes at the next posedge when write is high and waitrequest low.
  always @(negedge iCLK) begin
    if (iRSTn && bus_if.oBusWrite && !bus_if.iBusWaitRequest) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h be %h, expected no write",
                 bus_if.oBusAddress, bus_if.oBusWriteData, bus_if.oBusByteEnable);
      end else begin
        logic [67:0] e;
        e = sb.pop_front();
        chk("mon_addr", bus_if.oBusAddress, e[67:36]);
        chk("mon_data", bus_if.oBusWriteData, e[35:4]);
        chk("mon_be", {28'd0, bus_if.oBusByteEnable}, {28'd0, e[3:0]});
      end
    end
  end

  initial begin
    iRSTn = 1'b0; iWrReq = 1'b0; iAddress = 32'd0; iData = 32'd0;
    iByteEnable = 4'd0; iException = 1'b0; iLoadAddr = 32'd0;
    bus_if.iBusWaitRequest = 1'b0;

    // Reset state
    #2;
    chk("rst_buswrite", {31'd0, bus_if.oBusWrite}, 32'd0);
    chk("rst_addr", bus_if.oBusAddress, 32'd0);
    chk("rst_data", bus_if.oBusWriteData, 32'd0);
    chk("rst_be", {28'd0, bus_if.oBusByteEnable}, 32'd0);
    chk("rst_fault", {31'd0, oStoreFault}, 32'd0);
    chk("rst_full", {31'd0, oFull}, 32'd0);
    chk("rst_empty", {31'd0, oEmpty}, 32'd1);
    #10 iRSTn = 1'b1;

    // 1: single store, 2-cycle latency, one-cycle write
    do_store(32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1);
    @(negedge iCLK);
    chk("t1_wr_lat1", {31'd0, bus_if.oBusWrite}, 32'd0);
    chk("t1_notempty", {31'd0, oEmpty}, 32'd0);
    @(negedge iCLK);
    chk("t1_wr_lat2", {31'd0, bus_if.oBusWrite}, 32'd1);
    chk("t1_addr", bus_if.oBusAddress, 32'h0000_1004);
    @(negedge iCLK);
    chk("t1_wr_drop", {31'd0, bus_if.oBusWrite}, 32'd0);
    chk("t1_empty", {31'd0, oEmpty}, 32'd1);

    // 2: fill with waitrequest held, 5th store rejected, back-to-back drain
    bus_if.iBusWaitRequest = 1'b1;
    do_store(32'h0000_2000, 32'hAAAA_AAAA, 4'b0001, 1'b0, 1'b1);
    do_store(32'h0000_2001, 32'hBBBB_BBBB, 4'b0010, 1'b0, 1'b1);
    do_store(32'h0000_2002, 32'hCCCC_CCCC, 4'b0100, 1'b0, 1'b1);
    do_store(32'h0000_2003, 32'hDDDD_DDDD, 4'b1000, 1'b0, 1'b1);
    @(negedge iCLK);
    chk("t2_full", {31'd0, oFull}, 32'd1);
    do_store(32'h0000_2000, 32'hEEEE_EEEE, 4'b0001, 1'b0, 1'b0);
    @(negedge iCLK);
    chk("t2_still_full", {31'd0, oFull}, 32'd1);
    @(posedge iCLK); #1;
    bus_if.iBusWaitRequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      chk("t2_b2b_write", {31'd0, bus_if.oBusWrite}, 32'd1);
    end
    @(negedge iCLK);
    chk("t2_done_write", {31'd0, bus_if.oBusWrite}, 32'd0);
    chk("t2_notfull", {31'd0, oFull}, 32'd0);
    chk("t2_empty", {31'd0, oEmpty}, 32'd1);

    // 3: wait-state hold
    bus_if.iBusWaitRequest = 1'b1;
    do_store(32'h0000_3000, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b1);
    @(negedge iCLK);
    @(negedge iCLK);
    chk("t3_write", {31'd0, bus_if.oBusWrite}, 32'd1);
    s_a = bus_if.oBusAddress; s_d = bus_if.oBusWriteData; s_be = bus_if.oBusByteEnable;
    chk("t3_addr", s_a, 32'h0000_3000);
    for (int i = 0; i < 2; i++) begin
      @(negedge iCLK);
      chk("t3_hold_addr", bus_if.oBusAddress, s_a);
      chk("t3_hold_data", bus_if.oBusWriteData, s_d);
      chk("t3_hold_be", {28'd0, bus_if.oBusByteEnable}, {28'd0, s_be});
      chk("t3_hold_write", {31'd0, bus_if.oBusWrite}, 32'd1);
    end
    @(posedge iCLK); #1;
    bus_if.iBusWaitRequest = 1'b0;
    @(negedge iCLK);
    chk("t3_not_popped", {31'd0, oEmpty}, 32'd0);
    chk("t3_hold_data2", bus_if.oBusWriteData, 32'hCAFE_F00D);
    @(negedge iCLK);
    chk("t3_popped", {31'd0, oEmpty}, 32'd1);

    // 4: misaligned store faults; zero-BE store ignored silently
    do_store(32'h0000_4002, 32'h0000_0000, 4'b0000, 1'b1, 1'b0);
    @(negedge iCLK);
    chk("t4_fault", {31'd0, oStoreFault}, 32'd1);
    chk("t4_empty", {31'd0, oEmpty}, 32'd1);
    @(negedge iCLK);
    chk("t4_fault_end", {31'd0, oStoreFault}, 32'd0);
    do_store(32'h0000_4100, 32'h5555_5555, 4'b0000, 1'b0, 1'b0);
    @(negedge iCLK);
    chk("t4_ign_fault", {31'd0, oStoreFault}, 32'd0);
    chk("t4_ign_empty", {31'd0, oEmpty}, 32'd1);

    // 5: load hazard
    bus_if.iBusWaitRequest = 1'b1;
    do_store(32'h0000_5008, 32'h1234_5678, 4'b1111, 1'b0, 1'b1);
    iLoadAddr = 32'h0000_500B; #1;
    chk("t5_hit", {31'd0, oLoadHazard}, 32'd1);
    @(negedge iCLK); @(negedge iCLK);
    chk("t5_hit_inflight", {31'd0, oLoadHazard}, 32'd1);
    iLoadAddr = 32'h0000_500C; #1;
    chk("t5_miss", {31'd0, oLoadHazard}, 32'd0);
    iLoadAddr = 32'h0000_6000;
    @(posedge iCLK); #1;
    iWrReq = 1'b1; iAddress = 32'h0000_6000; iData = 32'h0BAD_CAFE; iByteEnable = 4'b1111;
    sb.push_back({32'h0000_6000, 32'h0BAD_CAFE, 4'b1111});
    #1;
    chk("t5_same_cycle", {31'd0, oLoadHazard}, 32'd0);
    @(posedge iCLK); #1;
    iWrReq = 1'b0;
    chk("t5_after_accept", {31'd0, oLoadHazard}, 32'd1);
    bus_if.iBusWaitRequest = 1'b0;
    repeat (4) @(negedge iCLK);
    iLoadAddr = 32'h0000_500B; #1;
    chk("t5_cleared", {31'd0, oLoadHazard}, 32'd0);
    chk("t5_empty", {31'd0, oEmpty}, 32'd1);

    // 6: async reset mid-write abandons queued stores
    bus_if.iBusWaitRequest = 1'b1;
    do_store(32'h0000_7000, 32'h7777_7777, 4'b1111, 1'b0, 1'b0);
    do_store(32'h0000_7004, 32'h8888_8888, 4'b1111, 1'b0, 1'b0);
    @(negedge iCLK);
    chk("t6_inflight", {31'd0, bus_if.oBusWrite}, 32'd1);
    #2 iRSTn = 1'b0;
    #1;
    chk("t6_rst_write", {31'd0, bus_if.oBusWrite}, 32'd0);
    chk("t6_rst_empty", {31'd0, oEmpty}, 32'd1);
    chk("t6_rst_addr", bus_if.oBusAddress, 32'd0);
    @(negedge iCLK);
    bus_if.iBusWaitRequest = 1'b0;
    #1 iRSTn = 1'b1;
    repeat (6) @(negedge iCLK);
    chk("t6_no_write", {31'd0, bus_if.oBusWrite}, 32'd0);
    chk("t6_empty", {31'd0, oEmpty}, 32'd1);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
